cell_vector_sequencer: RTL
==========================

// Module: cell_vector_sequencer
// PURPOSE
//  Drive side of the switch-level cell harness: accepts test vectors over valid/ready, applies them to the
//  gate inputs of a transistor-level cell built from the NMOS/PMOS primitives, waits a settle window, then
//  samples the cell outputs and returns a pass/fail/floating/contention verdict over valid/ready.
//  Sits in sim/hvl between the vector source and the DUT cell netlist; one vector in flight at a time.
// PARAMETERS
//  N_IN          4   width of cell input bus driven to transistor gates
//  N_OUT         2   width of cell output bus sampled back
//  SETTLE_CYCLES 3   clk cycles between applying inputs and sampling outputs (>=1)
//  CNT_W         8   width of vector sequence counter
// PORTS
//  clk          in   1      single clock; all state on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  vec_valid    in   1      request: vector present
//  vec_ready    out  1      sequencer can accept a vector
//  vec_in       in   N_IN   input values to apply
//  vec_exp      in   N_OUT  expected output values
//  vec_mask     in   N_OUT  1 = compare this output bit, 0 = don't care
//  cell_in      out  N_IN   registered drive to cell gate inputs
//  cell_out     in   N_OUT  cell outputs (4-state: 0/1/X/Z)
//  rsp_valid    out  1      verdict present
//  rsp_ready    in   1      consumer accepts verdict
//  rsp_pass     out  1      all masked bits equal expected and resolved to 0/1
//  rsp_float    out  N_OUT  per-bit: sampled value Z (no network conducting)
//  rsp_xbit     out  N_OUT  per-bit: sampled value X (pull-up/pull-down contention)
//  rsp_seq      out  CNT_W  sequence number of the vector this verdict belongs to
// BEHAVIOUR
//  Reset (rst_n=0, immediate): state=IDLE, vec_ready=0 until first clk after release, cell_in='0,
//   rsp_valid=0, rsp_pass=0, rsp_float='0, rsp_xbit='0, rsp_seq='0, settle counter=0, seq counter=0.
//  FSM: IDLE -> SETTLE -> SAMPLE -> RESP -> IDLE.
//   IDLE: vec_ready=1. On vec_valid&&vec_ready: register vec_in into cell_in, latch vec_exp/vec_mask,
//    load settle counter with SETTLE_CYCLES-1, go SETTLE. cell_in changes only on this acceptance edge.
//   SETTLE: vec_ready=0; decrement counter each cycle; when counter==0 go SAMPLE.
//   SAMPLE: one cycle; capture cell_out; per bit i: float[i]=(cell_out[i]===1'bz), xbit[i]=(cell_out[i]===1'bx);
//    pass = for all i with mask[i]: cell_out[i] is 0/1 and equals exp[i]. Z/X on unmasked bits is still
//    reported in rsp_float/rsp_xbit but does not fail. Go RESP with rsp_valid=1.
//   RESP: hold all rsp_* stable while rsp_valid&&!rsp_ready. On rsp_ready: rsp_valid=0, seq counter+1,
//    go IDLE. cell_in keeps last applied vector (no return-to-zero).
//  Latency: acceptance edge to rsp_valid rising = SETTLE_CYCLES+1 cycles.
//  rsp_seq = seq counter value at acceptance; counter wraps 2^CNT_W-1 -> 0 silently.
//  vec_ready is a function of state only (no combinational path from rsp_ready); a new vector is accepted
//   no earlier than the cycle after the response handshake, so back-to-back throughput is 1 per SETTLE_CYCLES+3.
//  vec_valid while busy: ignored, source must hold; vec_* sampled only on the handshake edge.
//  rst_n asserted mid-sequence: abort; in-flight vector is dropped with no response; cell_in returns to '0.
//  Comparison uses case-equality (===) on 4-state values; 2-state compare is forbidden (hides Z/X).
// STRUCTURE
//  Shared package cell_harness_pkg: typedef enum logic [1:0] {IDLE,SETTLE,SAMPLE,RESP} seq_state_t;
//   verdict struct (pass, float, xbit, seq) parameterised widths via localparams; default N_IN/N_OUT.
//  One sub-module: cell_out_classifier (combinational, 4-state cell_out + exp + mask -> pass/float/xbit),
//   reused by the standalone cell checkers. FSM, counters and handshake registers live in the top.
// TESTING  (DUT = CMOS inverter pair / NAND2 built from the NMOS and PMOS primitives)
//  1. Reset: rst_n=0 for 2 cycles -> cell_in=0, rsp_valid=0, vec_ready=0; first cycle after release -> vec_ready=1.
//  2. NAND2 vec_in=4'b0011, exp=2'b00, mask=2'b01 -> rsp_valid exactly 4 cycles after accept (SETTLE=3),
//     rsp_pass=1, rsp_float=0, rsp_xbit=0, rsp_seq=0.
//  3. Deliberate wrong exp=1 on inverter output for input 1 -> rsp_pass=0, rsp_xbit=0, rsp_float=0.
//  4. Output with PMOS network removed, input driving pull-down off -> rsp_float[0]=1, rsp_pass=0; same bit
//     unmasked -> rsp_float[0]=1, rsp_pass=1.
//  5. Both networks forced on (contention) -> rsp_xbit[0]=1, rsp_pass=0.
//  6. rsp_ready held low 5 cycles -> rsp_* stable, vec_ready=0 throughout; 256 vectors with CNT_W=8 ->
//     rsp_seq wraps 255 -> 0; rst_n pulse during SETTLE -> no rsp_valid, next vector gets rsp_seq=0.

Source files
------------

// File: rtl/cell_harness_pkg.sv
// Shared types and default widths for the switch-level cell harness.
package cell_harness_pkg;

    localparam int unsigned N_IN_DEF          = 4;
    localparam int unsigned N_OUT_DEF         = 2;
    localparam int unsigned SETTLE_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF         = 8;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RESP} seq_state_t;

    typedef struct packed {
        logic                 pass;
        logic [N_OUT_DEF-1:0] flt;
        logic [N_OUT_DEF-1:0] xbit;
        logic [CNT_W_DEF-1:0] seq;
    } verdict_t;

endpackage

// File: rtl/cell_vector_sequencer_if.sv
// Vector request and verdict response handshakes between source and sequencer.
interface cell_vector_sequencer_if
    import cell_harness_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             vec_valid;
    logic             vec_ready;
    logic [N_IN-1:0]  vec_in;
    logic [N_OUT-1:0] vec_exp;
    logic [N_OUT-1:0] vec_mask;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_pass;
    logic [N_OUT-1:0] rsp_float;
    logic [N_OUT-1:0] rsp_xbit;
    logic [CNT_W-1:0] rsp_seq;

    modport master (
        output vec_valid, vec_in, vec_exp, vec_mask, rsp_ready,
        input  vec_ready, rsp_valid, rsp_pass, rsp_float, rsp_xbit, rsp_seq
    );

    modport slave (
        input  vec_valid, vec_in, vec_exp, vec_mask, rsp_ready,
        output vec_ready, rsp_valid, rsp_pass, rsp_float, rsp_xbit, rsp_seq
    );

endinterface

// File: rtl/cell_out_classifier.sv
// Classifies 4-state cell outputs against expected values under a compare mask.
module cell_out_classifier #(
    parameter int unsigned N_OUT = 2
) (
    input  logic [N_OUT-1:0] cell_out,
    input  logic [N_OUT-1:0] exp,
    input  logic [N_OUT-1:0] mask,
    output logic             pass,
    output logic [N_OUT-1:0] flt,
    output logic [N_OUT-1:0] xbit
);

    always_comb begin
        pass = 1'b1;
        flt  = '0;
        xbit = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            // an unresolved bit that is not X can only be Z
            if ($isunknown(cell_out[i])) begin
                xbit[i] = (cell_out[i] === 1'bx);
                flt[i]  = (cell_out[i] !== 1'bx);
            end
            if (mask[i] && ($isunknown(cell_out[i]) || (cell_out[i] !== exp[i])))
                pass = 1'b0;
        end
    end

endmodule

// File: rtl/cell_vector_sequencer.sv
// Applies one test vector at a time to a cell, waits a settle window, then returns a verdict.
module cell_vector_sequencer
    import cell_harness_pkg::*;
#(
    parameter int unsigned N_IN          = N_IN_DEF,
    parameter int unsigned N_OUT         = N_OUT_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cell_vector_sequencer_if.slave        bus,
    output logic [N_IN-1:0]               cell_in,
    input  logic [N_OUT-1:0]              cell_out
);

    localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

    seq_state_t       state, state_nx;
    logic [SC_W-1:0]  settle_cnt;
    logic [CNT_W-1:0] seq_cnt;
    logic [N_OUT-1:0] exp_q, mask_q;
    logic             accept, sample, done;

    logic             cls_pass;
    logic [N_OUT-1:0] cls_flt, cls_xbit;

    cell_out_classifier #(.N_OUT(N_OUT)) u_classifier (
        .cell_out (cell_out),
        .exp      (exp_q),
        .mask     (mask_q),
        .pass     (cls_pass),
        .flt      (cls_flt),
        .xbit     (cls_xbit)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        sample   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.vec_valid && bus.vec_ready) begin
                    accept   = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) state_nx = SAMPLE;
            end
            SAMPLE: begin
                sample   = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // vec_ready is registered from next state so it stays low in the first cycle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.vec_ready <= 1'b0;
            cell_in       <= '0;
            exp_q         <= '0;
            mask_q        <= '0;
            settle_cnt    <= '0;
            seq_cnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_pass  <= 1'b0;
            bus.rsp_float <= '0;
            bus.rsp_xbit  <= '0;
            bus.rsp_seq   <= '0;
        end else begin
            state         <= state_nx;
            bus.vec_ready <= (state_nx == IDLE);
            if (accept) begin
                cell_in    <= bus.vec_in;
                exp_q      <= bus.vec_exp;
                mask_q     <= bus.vec_mask;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (sample) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_pass  <= cls_pass;
                bus.rsp_float <= cls_flt;
                bus.rsp_xbit  <= cls_xbit;
                bus.rsp_seq   <= seq_cnt;
            end
            if (done) begin
                bus.rsp_valid <= 1'b0;
                seq_cnt       <= seq_cnt + 1'b1;
            end
        end
    end

endmodule
